// File: rtl/pe_result_fifo_if.sv
// AXI4-Stream beat channel carrying PE-array results downstream.
interface pe_result_fifo_if #(
  parameter int unsigned phit_size = 512
);
  localparam int unsigned KW = phit_size / 8;

  logic [phit_size-1:0] tdata;
  logic [KW-1:0]        tkeep;
  logic                 tlast;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/pe_result_fifo.sv
// Result FIFO behind the type-C PE array: absorbs un-throttled lane results
// and replays them as first-word-fall-through AXI4-Stream beats.
module pe_result_fifo #(
  parameter int unsigned phit_size    = 512,
  parameter int unsigned SIMD_degree  = 16,
  parameter int unsigned dwidth_float = 32,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned AF_SLACK     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [phit_size-1:0]     i_data,
  input  logic [SIMD_degree-1:0]   i_tvalid,
  input  logic [SIMD_degree-1:0]   i_tlast,
  pe_result_fifo_if.master         m_axis,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [31:0]              pkt_count,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int unsigned KW  = phit_size / 8;
  localparam int unsigned BPL = dwidth_float / 8;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef struct packed {
    logic [phit_size-1:0] data;
    logic [KW-1:0]        keep;
    logic                 last;
  } entry_t;

  entry_t         mem [0:DEPTH-1];
  entry_t         wr_entry;
  entry_t         head_entry;
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic           tvalid_q;
  logic           wr;
  logic           rd;
  logic           full;
  logic           wr_acc;
  logic [CW-1:0]  fill_next;

  // Pack the incoming vector; absent lanes keep their data but lose byte enables.
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = i_data;
    wr_entry.last = |(i_tvalid & i_tlast);
    for (int unsigned i = 0; i < SIMD_degree; i++) begin
      wr_entry.keep[i*BPL +: BPL] = {BPL{i_tvalid[i]}};
    end
  end

  // A write into a full FIFO still lands when the head is leaving the same cycle.
  always_comb begin
    head_entry = mem[head];
    wr         = |i_tvalid;
    rd         = tvalid_q & m_axis.tready;
    full       = (fill_level == CW'(DEPTH));
    wr_acc     = wr & (~full | rd);
    fill_next  = fill_level;
    if (wr_acc && !rd) begin
      fill_next = fill_level + CW'(1);
    end else if (rd && !wr_acc) begin
      fill_next = fill_level - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      fill_level  <= '0;
      tvalid_q    <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      pkt_count   <= '0;
    end else begin
      if (wr_acc) begin
        tail <= tail + AW'(1);
      end
      if (rd) begin
        head <= head + AW'(1);
      end
      if (rd && head_entry.last) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (wr && !wr_acc) begin
        overflow <= 1'b1;
      end
      fill_level  <= fill_next;
      tvalid_q    <= (fill_next != '0);
      almost_full <= (fill_next >= CW'(DEPTH - AF_SLACK));
    end
  end

  // Storage is not reset; stale entries are masked by tvalid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[tail] <= wr_entry;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = head_entry.data;
  assign m_axis.tkeep  = tvalid_q ? head_entry.keep : '0;
  assign m_axis.tlast  = tvalid_q & head_entry.last;

endmodule
